dpti_sync_fifo_if: RTL and testbench

//  Bus-side front end for the FT2232H (DPTI) in 245 synchronous FIFO mode.

---
 rtl/dpti_sync_fifo_if.sv | 165 ++++++++++++++++
 tb/tb_dpti_sync_fifo_if.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpti_sync_fifo_if.sv
// rtl/dpti_sync_fifo_if.sv - FT2232H 245 synchronous FIFO bus front end
// Shares the half-duplex prog_d bus between the RX outport and the TX inport, all in prog_clko.
module dpti_sync_fifo_if #(
  parameter int RX_FIFO_DEPTH = 8,
  parameter int BURST_MAX     = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxf_i,
  input  logic       txe_i,
  input  logic [7:0] data_in_i,
  output logic       rdn_o,
  output logic       wrn_o,
  output logic       oen_o,
  output logic       siwua_o,
  output logic [7:0] data_out_o,
  input  logic       inport_valid_i,
  input  logic [7:0] inport_data_i,
  output logic       inport_ready_o,
  output logic       outport_valid_o,
  output logic [7:0] outport_data_o,
  input  logic       outport_ready_i
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [AW:0]   RX_HI      = LW'(RX_FIFO_DEPTH - 2);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX_TURN = 3'd1;
  localparam logic [2:0] S_RX      = 3'd2;
  localparam logic [2:0] S_TX      = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  logic [2:0]    state;
  logic          last_dir;
  logic [CW-1:0] burst_cnt;

  logic [7:0]    rx_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   rx_level;
  logic          rx_push, rx_pop, rx_ok;

  logic [7:0]    tx_mem [2];
  logic          tx_wr_ptr, tx_rd_ptr;
  logic [1:0]    tx_count, tx_count_nxt;
  logic          tx_push, tx_pop, tx_ok;

  assign siwua_o = 1'b1;

  assign rx_push         = !rdn_o && !rxf_i;
  assign rx_pop          = outport_valid_o && outport_ready_i;
  assign outport_valid_o = (rx_level != '0);
  assign outport_data_o  = rx_mem[rx_rd_ptr];
  assign rx_ok           = !rxf_i && (rx_level < RX_HI);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + LW'(1);
        2'b01:   rx_level <= rx_level - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= data_in_i;
  end

  // A write strobe with TXE# high is not an accept; the head stays put for the retry.
  assign tx_push    = inport_valid_i && inport_ready_o;
  assign tx_pop     = !wrn_o && !txe_i;
  assign tx_ok      = !txe_i && (tx_count != 2'd0);
  assign data_out_o = tx_mem[tx_rd_ptr];

  always_comb begin
    tx_count_nxt = tx_count;
    if (tx_push && !tx_pop)      tx_count_nxt = tx_count + 2'd1;
    else if (!tx_push && tx_pop) tx_count_nxt = tx_count - 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_mem[0]      <= 8'h00;
      tx_mem[1]      <= 8'h00;
      tx_wr_ptr      <= 1'b0;
      tx_rd_ptr      <= 1'b0;
      tx_count       <= 2'd0;
      inport_ready_o <= 1'b0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_ptr] <= inport_data_i;
        tx_wr_ptr         <= ~tx_wr_ptr;
      end
      if (tx_pop) tx_rd_ptr <= ~tx_rd_ptr;
      tx_count       <= tx_count_nxt;
      inport_ready_o <= (tx_count_nxt != 2'd2);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      rdn_o     <= 1'b1;
      wrn_o     <= 1'b1;
      oen_o     <= 1'b1;
      last_dir  <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          burst_cnt <= '0;
          // When both sides are ready, serve the one that did not go last.
          if (rx_ok && (!tx_ok || last_dir)) begin
            oen_o <= 1'b0;
            state <= S_RX_TURN;
          end else if (tx_ok) begin
            wrn_o <= 1'b0;
            state <= S_TX;
          end
        end
        S_RX_TURN: begin
          rdn_o <= 1'b0;
          state <= S_RX;
        end
        S_RX: begin
          if (rx_push) burst_cnt <= burst_cnt + CW'(1);
          if (rxf_i || (rx_level >= RX_HI) || (rx_push && (burst_cnt == BURST_LAST))) begin
            rdn_o    <= 1'b1;
            last_dir <= 1'b0;
            state    <= S_GAP;
          end
        end
        S_TX: begin
          if (tx_pop) burst_cnt <= burst_cnt + CW'(1);
          if (txe_i || (tx_count_nxt == 2'd0) || (tx_pop && (burst_cnt == BURST_LAST))) begin
            wrn_o    <= 1'b1;
            last_dir <= 1'b1;
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          oen_o <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          rdn_o <= 1'b1;
          wrn_o <= 1'b1;
          oen_o <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpti_sync_fifo_if.sv
// tb/tb_dpti_sync_fifo_if.sv - scoreboard bench for dpti_sync_fifo_if
// Models the FT2232H side and both stream endpoints; depth 8, burst limit 4.
module tb_dpti_sync_fifo_if;

  localparam int DEPTH = 8;
  localparam int BMAX  = 4;

  logic       clk_i;
  logic       rst_i;
  logic       rxf_i, txe_i;
  logic [7:0] data_in_i;
  logic       rdn_o, wrn_o, oen_o, siwua_o;
  logic [7:0] data_out_o;
  logic       inport_valid_i;
  logic [7:0] inport_data_i;
  logic       inport_ready_o;
  logic       outport_valid_o;
  logic [7:0] outport_data_o;
  logic       outport_ready_i;

  dpti_sync_fifo_if #(.RX_FIFO_DEPTH(DEPTH), .BURST_MAX(BMAX)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rxf_i          (rxf_i),
    .txe_i          (txe_i),
    .data_in_i      (data_in_i),
    .rdn_o          (rdn_o),
    .wrn_o          (wrn_o),
    .oen_o          (oen_o),
    .siwua_o        (siwua_o),
    .data_out_o     (data_out_o),
    .inport_valid_i (inport_valid_i),
    .inport_data_i  (inport_data_i),
    .inport_ready_o (inport_ready_o),
    .outport_valid_o(outport_valid_o),
    .outport_data_o (outport_data_o),
    .outport_ready_i(outport_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct { bit dir; int len; } burst_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] rx_src[$], in_src[$], rx_exp[$], tx_exp[$];
  burst_t bursts[$];
  bit rxf_en, txe_en, rdy_en, vld_en, rnd_mode, rec;
  int cyc, rd_run, wr_run, tx_acc, rx_pop_cnt;
  logic p_rdn, p_wrn, p_oen, p_rxf, p_txe;
  bit oen_fell_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
  endtask

  task automatic clear_model();
    rx_exp.delete();
    tx_exp.delete();
    rd_run = 0; wr_run = 0;
    p_rdn = 1'b1; p_wrn = 1'b1; p_oen = 1'b1; p_rxf = 1'b1; p_txe = 1'b1;
    oen_fell_last = 1'b0;
  endtask

  task automatic cycle();
    bit oen_fell, rdn_fell;
    @(negedge clk_i);
    cyc++;
    // state left by the previous edge
    check("strobe_excl", !rdn_o && !wrn_o, 0);
    if (!wrn_o) check("wrn_oen", oen_o, 1);
    if (!rdn_o) check("rdn_oen", oen_o, 0);
    check("siwua", siwua_o, 1);
    check("out_valid", outport_valid_o, rx_exp.size() != 0);
    if (tx_exp.size() != 0) check("tx_head", data_out_o, tx_exp[0]);
    if (!p_rdn && p_rxf) check("rdn_release", rdn_o, 1);
    if (!p_wrn && p_txe) check("wrn_release", wrn_o, 1);
    oen_fell = p_oen && !oen_o;
    rdn_fell = p_rdn && !rdn_o;
    if (rdn_fell) check("turn_oen", oen_fell_last, 1);
    if (oen_fell) check("turn_rdn", rdn_o, 1);
    oen_fell_last = oen_fell;
    if (!p_rdn && rdn_o) begin
      check("rx_burst_len", rd_run <= BMAX, 1);
      if (rec) bursts.push_back('{1'b0, rd_run});
      rd_run = 0;
    end
    if (!p_wrn && wrn_o) begin
      check("tx_burst_len", wr_run <= BMAX, 1);
      if (rec) bursts.push_back('{1'b1, wr_run});
      wr_run = 0;
    end

    if (rnd_mode) begin
      rxf_en = ($urandom_range(0, 3) != 0);
      txe_en = ($urandom_range(0, 3) != 0);
      rdy_en = ($urandom_range(0, 1) != 0);
      vld_en = ($urandom_range(0, 3) != 0);
    end
    rxf_i           = !(rxf_en && rx_src.size() != 0);
    data_in_i       = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
    txe_i           = !txe_en;
    outport_ready_i = rdy_en;
    inport_valid_i  = vld_en && in_src.size() != 0;
    inport_data_i   = (in_src.size() != 0) ? in_src[0] : 8'h00;

    // events of the coming edge
    if (!rdn_o && !rxf_i) begin
      rx_exp.push_back(rx_src.pop_front());
      rd_run++;
    end
    if (outport_valid_o && outport_ready_i) begin
      if (rx_exp.size() == 0) check("rx_extra", outport_valid_o, 0);
      else check("rx_data", outport_data_o, rx_exp.pop_front());
      rx_pop_cnt++;
    end
    if (!wrn_o && !txe_i) begin
      if (tx_exp.size() == 0) check("tx_extra", wrn_o, 1);
      else check("tx_data", data_out_o, tx_exp.pop_front());
      wr_run++;
      tx_acc++;
    end
    if (inport_valid_i && inport_ready_o) tx_exp.push_back(in_src.pop_front());

    p_rdn = rdn_o; p_wrn = wrn_o; p_oen = oen_o; p_rxf = rxf_i; p_txe = txe_i;
  endtask

  task automatic drain();
    rxf_en = 1; txe_en = 1; rdy_en = 1; vld_en = 1; rnd_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rx_src.size() == 0 && in_src.size() == 0 && rx_exp.size() == 0 &&
          tx_exp.size() == 0 && rdn_o && wrn_o) break;
      cycle();
    end
    check("drain_rx", rx_src.size() + rx_exp.size(), 0);
    check("drain_tx", in_src.size() + tx_exp.size(), 0);
    repeat (3) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t_oen, t_rdn, hold;
    rst_i = 1'b0; rxf_i = 1'b1; txe_i = 1'b1; data_in_i = 8'h00;
    inport_valid_i = 1'b0; inport_data_i = 8'h00; outport_ready_i = 1'b0;
    rxf_en = 0; txe_en = 0; rdy_en = 0; vld_en = 0; rnd_mode = 0; rec = 0;
    cyc = 0; tx_acc = 0; rx_pop_cnt = 0;
    clear_model();
    #1 rst_i = 1'b1;
    #1;
    check("rst_rdn", rdn_o, 1);
    check("rst_wrn", wrn_o, 1);
    check("rst_oen", oen_o, 1);
    check("rst_siwua", siwua_o, 1);
    check("rst_data_out", data_out_o, 0);
    check("rst_inport_ready", inport_ready_o, 0);
    check("rst_outport_valid", outport_valid_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) cycle();
    check("ready_after_rst", inport_ready_o, 1);

    // RX 0x11..0x15 with the consumer always ready
    for (int i = 0; i < 5; i++) rx_src.push_back(8'(8'h11 + i));
    rxf_en = 1; rdy_en = 1; txe_en = 0; vld_en = 0;
    rx_pop_cnt = 0; t_oen = -1; t_rdn = -1;
    for (int i = 0; i < 60; i++) begin
      if (rx_src.size() == 0 && rx_exp.size() == 0 && rdn_o && i > 2) break;
      cycle();
      if (t_oen < 0 && !oen_o) t_oen = cyc;
      if (t_rdn < 0 && !rdn_o) t_rdn = cyc;
    end
    check("t2_turnaround", t_rdn - t_oen, 1);
    check("t2_count", rx_pop_cnt, 5);
    repeat (4) cycle();

    // consumer stalled: reading must stop at DEPTH-1 bytes
    for (int i = 0; i < 20; i++) rx_src.push_back(8'(8'h30 + i));
    rdy_en = 0;
    repeat (40) cycle();
    check("t3_level", rx_exp.size(), DEPTH - 1);
    check("t3_rdn_idle", rdn_o, 1);
    check("t3_src_left", rx_src.size(), 20 - (DEPTH - 1));
    check("t3_valid", outport_valid_o, 1);
    drain();

    // TX A0..A3 with TXE# high for three edges once A1 is taken
    for (int i = 0; i < 4; i++) in_src.push_back(8'(8'hA0 + i));
    rxf_en = 0; vld_en = 1; txe_en = 1; tx_acc = 0; hold = 0;
    for (int i = 0; i < 80; i++) begin
      if (tx_acc == 4) break;
      if (tx_acc == 2 && hold < 3) begin txe_en = 0; hold++; end
      else txe_en = 1;
      cycle();
      if (!txe_en) check("t4_hold", data_out_o, 8'hA2);
    end
    check("t4_sent", tx_acc, 4);
    repeat (5) cycle();
    check("t4_once", tx_acc, 4);
    check("t4_left", tx_exp.size(), 0);

    // both directions saturated: alternating bursts of BMAX
    for (int i = 0; i < 60; i++) begin
      rx_src.push_back(8'(8'h40 + i));
      in_src.push_back(8'(8'hC0 + i));
    end
    bursts.delete();
    rec = 1; rxf_en = 1; txe_en = 1; rdy_en = 1; vld_en = 1;
    repeat (70) cycle();
    rec = 0;
    check("t5_nbursts", bursts.size() >= 6, 1);
    for (int i = 0; i < 6 && i < bursts.size(); i++) begin
      check("t5_len", bursts[i].len, BMAX);
      if (i > 0) check("t5_alternate", bursts[i].dir, !bursts[i-1].dir);
    end
    drain();

    // async reset in the middle of an RX burst
    for (int i = 0; i < 10; i++) rx_src.push_back(8'(8'h60 + i));
    rxf_en = 1; rdy_en = 0; vld_en = 0; txe_en = 0;
    for (int i = 0; i < 40; i++) begin
      if (!rdn_o && rd_run >= 2) break;
      cycle();
    end
    check("t1_in_rx", rdn_o, 0);
    @(negedge clk_i);
    check("t1_pre_valid", outport_valid_o, 1);
    rst_i = 1'b1;
    #1;
    check("t1_rdn", rdn_o, 1);
    check("t1_oen", oen_o, 1);
    check("t1_wrn", wrn_o, 1);
    check("t1_valid", outport_valid_o, 0);
    clear_model();
    rx_src.delete();
    rxf_en = 0; rxf_i = 1'b1; inport_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    rdy_en = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t1_no_out", outport_valid_o, 0);
    end

    // random traffic against the scoreboard
    rnd_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      while (rx_src.size() < 4) rx_src.push_back(8'($urandom));
      while (in_src.size() < 4) in_src.push_back(8'($urandom));
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
